// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD down-timer: load/start/stop/tick inputs
// from the controller, count and status flags back from the timer.
interface bcd_down_timer_if #(
    parameter int NDIGITS = 4
);
    logic                   load;
    logic [4*NDIGITS-1:0]   load_val;
    logic                   start;
    logic                   stop;
    logic                   pause;
    logic                   enb;
    logic [4*NDIGITS-1:0]   Q;
    logic                   running;
    logic                   expire;
    logic                   done;
    logic                   load_err;

    modport master (
        output load, load_val, start, stop, pause, enb,
        input  Q, running, expire, done, load_err
    );

    modport slave (
        input  load, load_val, start, stop, pause, enb,
        output Q, running, expire, done, load_err
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter/timer with load validation, pause, stop,
// optional auto-reload, combinational expire and a registered done pulse.
module bcd_down_timer #(
    parameter int NDIGITS     = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    bcd_down_timer_if.slave bus
);
    localparam int W = 4 * NDIGITS;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   rl_q, rl_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           tick;
    logic           at_one;

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Borrow enters at digit 0; a zero digit that takes a borrow wraps to 9.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick   = (state_q == RUN) && bus.enb && !bus.pause;
    assign at_one = (q_q == ONE);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rl_d    = rl_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (bus.load) begin
            if (bcd_valid(bus.load_val)) begin
                q_d     = bus.load_val;
                rl_d    = bus.load_val;
                state_d = IDLE;
                err_d   = 1'b0;
            end else begin
                err_d   = 1'b1;
            end
        end else if (bus.stop && state_q == RUN) begin
            state_d = IDLE;
        end else if (bus.start && state_q == IDLE) begin
            if (q_q != '0) state_d = RUN;
            else           done_d  = 1'b1;
        end else if (tick && q_q != '0) begin
            if (at_one) begin
                done_d = 1'b1;
                // A zero reload value would re-expire immediately, so stop instead.
                if (AUTO_RELOAD && rl_q != '0) begin
                    q_d = rl_q;
                end else begin
                    q_d     = '0;
                    state_d = IDLE;
                end
            end else begin
                q_d = bcd_dec(q_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            rl_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rl_q    <= rl_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.Q        = q_q;
    assign bus.running  = (state_q == RUN);
    assign bus.expire   = tick && at_one;
    assign bus.done     = done_q;
    assign bus.load_err = err_q;
endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
Multi-digit BCD down-counter/timer, the count-down counterpart of the radix-10 up-counter used for display and timing. It is loaded with a BCD value, started, and then decrements once per enb tick. Borrow ripples digit to digit. It flags expiry combinationally, like the up-counter carry, and also pulses a registered done. Used for MAC timeouts, backoff slots and countdown displays.

Parameters:
NDIGITS, 4, number of BCD digits; Q width is 4*NDIGITS.
AUTO_RELOAD, 0, 1 = on expiry reload the last valid loaded value and keep running; 0 = stop at zero.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
load  input  1  load load_val (synchronous).
load_val  input  4*NDIGITS  BCD load value; digit 0 in bits [3:0].
start  input  1  begin counting (synchronous).
stop  input  1  halt counting and hold Q.
pause  input  1  level; while high, enb ticks are ignored in RUN.
enb  input  1  decrement tick (e.g. from a rate divider).
Q  output  4*NDIGITS  current BCD count.
running  output  1  high in RUN state.
expire  output  1  combinational; running & enb & ~pause & (Q == 1).
done  output  1  registered one-cycle pulse, one cycle after expire or after start with Q == 0.
load_err  output  1  sticky; last load attempt contained a digit > 9.

Behaviour:
- Reset (async, active-high): Q=0, reload register=0, state IDLE, running=0, done=0, load_err=0.
- States are IDLE and RUN; running = (state==RUN). Synchronous priority, highest first: load, stop, start, tick.
- load, any state:
  - All digits <= 9: Q and reload register <= load_val, state <= IDLE, load_err <= 0.
  - Any digit > 9: Q, reload register and state unchanged; load_err <= 1.
  - start or stop in the same cycle is ignored.
- stop: RUN -> IDLE, Q held. In IDLE, stop has no effect.
- start in IDLE:
  - Q != 0: -> RUN next cycle.
  - Q == 0: stays IDLE; done pulses next cycle.
  - start in RUN is ignored.
- Tick in RUN (enb & ~pause):
  - Q decrements by 1 in BCD.
  - Digit 0 decrements. Any digit that is 0 and receives a borrow becomes 9 and passes the borrow up.
  - Q never decrements below 0.
- Expiry (tick with Q == 1, expire high that cycle):
  - AUTO_RELOAD=0: Q <= 0, state <= IDLE.
  - AUTO_RELOAD=1: Q <= reload register, stay RUN. If the reload register is 0, go IDLE with Q=0.
  - In both cases done=1 for exactly the next cycle.
- Ticks in IDLE, or with pause high, change nothing; expire stays 0.
- pause does not affect load, stop or start.
- expire is purely combinational; done is registered from expire, or from the start-at-zero case.
- Reset mid-count: outputs clear asynchronously. No done pulse is generated on reset release.
- Q digits always stay within 0..9 after reset; an invalid value is never stored.

Test Plan:
- Reset/load: assert reset mid-RUN -> Q=0, running=0, done=0 immediately. Load 0x0012, start, 12 ticks -> Q passes 0x0010, 0x0009 (borrow) ... 0x0001. expire high on the 12th tick, Q=0x0000, done pulses next cycle, running=0.
- Multi-digit borrow: load 0x1000, start, one tick -> Q=0x0999. Load 0x0100, one tick -> Q=0x0099.
- Invalid load: load 0x12A4 -> Q unchanged, load_err=1. Then load 0x0005 -> Q=0x0005, load_err=0.
- Priority/control:
  - load and start in the same cycle -> IDLE with new Q.
  - pause high over 3 ticks -> Q constant.
  - stop at Q=0x0007 -> IDLE, Q held.
  - start again and continue -> reaches 0 after 7 ticks.
  - start with Q=0 -> done pulse, running stays 0.
- AUTO_RELOAD=1: load 0x0003, start, 7 ticks -> Q sequence 3,2,1,3,2,1,3; done pulses twice; running stays 1.
- Enb gaps: ticks every 5 cycles from load 0x0002 -> expire asserted only in the tick cycle, never in the cycles between ticks.
